jedro_1_ifu: RTL and testbench

Instruction fetch unit for the jedro_1 core. Sits between the synchronous instruction ROM (one-cycle read latency) and the decoder: it generates sequential fetch addresses, buffers returned words with their PC in a small prefetch FIFO, and hands them to the decoder over a valid/ready handshake. Branch and jump redirects from the execute stage flush the buffer and discard any in-flight read.

---
 rtl/jedro_1_ifu.sv | 109 ++++++++++
 tb/tb_jedro_1_ifu.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_ifu.sv
// Instruction fetch unit: sequential fetch from a one-cycle-latency ROM into a small
// prefetch FIFO, handed to the decoder over valid/ready; redirects flush the buffer.
`timescale 1ns/1ps

module jedro_1_ifu #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  output logic                  imem_en_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
  input  logic                  jmp_addr_valid_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  instr_valid_o,
  input  logic                  dec_ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  localparam logic [PW+1:0]       DEPTH_L = (PW+2)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(4);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] inflight_addr_q;
  logic                  inflight_q;
  logic [PW:0]           wr_ptr_q, rd_ptr_q, count;
  logic [PW+1:0]         occupancy;
  logic                  empty, push, pop, credit, issue;

  logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem  [FIFO_DEPTH];

  // Pointers carry an extra wrap bit, so the difference is the fill level 0..FIFO_DEPTH.
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (count == '0);

  assign instr_valid_o = !empty && !jmp_addr_valid_i;
  assign pop           = instr_valid_o && dec_ready_i;
  // A killed read never reaches here: a redirect clears inflight_q at the same edge.
  assign push          = inflight_q && !jmp_addr_valid_i;

  assign occupancy = {1'b0, count} + {{(PW+1){1'b0}}, inflight_q} - {{(PW+1){1'b0}}, pop};
  assign credit    = occupancy < DEPTH_L;
  assign issue     = (state_q == S_FETCH) && credit;

  assign imem_en_o    = issue;
  assign imem_addr_o  = pc_q;
  assign instr_o      = empty ? '0 : instr_mem[rd_ptr_q[PW-1:0]];
  assign instr_addr_o = empty ? '0 : addr_mem[rd_ptr_q[PW-1:0]];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: if (!credit) state_d = S_STALL;
      S_STALL: if (credit)  state_d = S_FETCH;
      default: state_d = S_BOOT;
    endcase
    if (jmp_addr_valid_i) state_d = S_FETCH;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q         <= S_BOOT;
      pc_q            <= {BOOT_ADDR[ADDR_WIDTH-1:2], 2'b00};
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
    end else begin
      state_q <= state_d;
      if (jmp_addr_valid_i) begin
        pc_q       <= {jmp_addr_i[ADDR_WIDTH-1:2], 2'b00};
        inflight_q <= 1'b0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        if (issue) pc_q <= pc_q + STEP;
        inflight_q <= issue;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (issue) inflight_addr_q <= pc_q;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers alone define which
  // entries are valid, and outputs are forced to zero while empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr_q[PW-1:0]] <= imem_rdata_i;
      addr_mem[wr_ptr_q[PW-1:0]]  <= inflight_addr_q;
    end
  end

endmodule

// File: tb/tb_jedro_1_ifu.sv
// Directed bench for jedro_1_ifu: boot timing, backpressure, redirects, FIFO wrap and
// asynchronous reset mid-stream, against a behavioural one-cycle-latency ROM.
`timescale 1ns/1ps

module tb_jedro_1_ifu;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata = '0;
  logic [AW-1:0] jmp_addr;
  logic          jmp_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_addr;
  logic          instr_valid;
  logic          dec_ready;

  int vectors     = 0;
  int miscompares = 0;

  jedro_1_ifu #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BOOT_ADDR(32'h0000_0000), .FIFO_DEPTH(4)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .imem_en_o        (imem_en),
    .imem_addr_o      (imem_addr),
    .imem_rdata_i     (imem_rdata),
    .jmp_addr_i       (jmp_addr),
    .jmp_addr_valid_i (jmp_valid),
    .instr_o          (instr),
    .instr_addr_o     (instr_addr),
    .instr_valid_o    (instr_valid),
    .dec_ready_i      (dec_ready)
  );

  always #5 clk = ~clk;

  // ROM contents: word i = addi x(i), x0, i  ->  0x00000013, 0x00100093, ...
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    logic [31:0] i;
    i = a >> 2;
    return (i << 20) | (i << 7) | 32'h13;
  endfunction

  always @(posedge clk) if (imem_en) imem_rdata <= rom_word(imem_addr);

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic restart(input logic ready);
    rstn      = 1'b0;
    jmp_valid = 1'b0;
    jmp_addr  = '0;
    dec_ready = ready;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; jmp_valid = 1'b0; jmp_addr = '0; dec_ready = 1'b0;
    #1;
    vectors++; if (imem_en !== 1'b0) begin miscompares++; $display("FAIL reset_en: got %b want 0", imem_en); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 0", instr); end
    vectors++; if (instr_addr !== 32'h0) begin miscompares++; $display("FAIL reset_instr_addr: got %h want 0", instr_addr); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Expects reset just released at a falling edge; checks cycles 1..3 then streaming.
  task automatic test_boot(input string tag, input int stream_len);
    dec_ready = 1'b1;
    tick; #1;
    vectors++; if (imem_en !== 1'b1) begin miscompares++; $display("FAIL %s_c1_en: got %b want 1", tag, imem_en); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL %s_c1_addr: got %h want 0", tag, imem_addr); end
    tick; #1;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL %s_c2_valid: got %b want 0", tag, instr_valid); end
    tick;
    for (int k = 0; k < stream_len; k++) begin
      #1;
      vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL %s_valid[%0d]: got %b want 1", tag, k, instr_valid); end
      vectors++; if (instr_addr !== 32'(4*k)) begin miscompares++; $display("FAIL %s_pc[%0d]: got %h want %h", tag, k, instr_addr, 32'(4*k)); end
      vectors++; if (instr !== rom_word(32'(4*k))) begin miscompares++; $display("FAIL %s_instr[%0d]: got %h want %h", tag, k, instr, rom_word(32'(4*k))); end
      tick;
    end
  endtask

  task automatic test_backpressure;
    int reqs;
    reqs = 0;
    restart(1'b1);
    for (int c = 1; c <= 9; c++) begin
      tick;
      if (c == 3) dec_ready = 1'b0;
      #1;
      if (imem_en) reqs++;
      if (c >= 5) begin
        vectors++; if (imem_en !== 1'b0) begin miscompares++; $display("FAIL bp_full_en[c%0d]: got %b want 0", c, imem_en); end
      end
    end
    vectors++; if (reqs !== 4) begin miscompares++; $display("FAIL bp_requests: got %0d want 4", reqs); end
    vectors++; if (instr_addr !== 32'h0) begin miscompares++; $display("FAIL bp_head: got %h want 0", instr_addr); end
    tick;
    dec_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      #1;
      vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL bp_drain_valid[%0d]: got %b want 1", j, instr_valid); end
      vectors++; if (instr_addr !== 32'(4*j)) begin miscompares++; $display("FAIL bp_drain_pc[%0d]: got %h want %h", j, instr_addr, 32'(4*j)); end
      tick;
    end
  endtask

  task automatic test_redirect;
    restart(1'b1);
    for (int c = 1; c <= 6; c++) begin
      tick;
      if (c == 5) dec_ready = 1'b0;
    end
    // Cycle 7: FIFO holds 0x8, 0xC, 0x10 with 0x14 in flight.
    tick;
    jmp_addr = 32'h40; jmp_valid = 1'b1;
    #1;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rd_strobe_valid: got %b want 0", instr_valid); end
    tick;
    jmp_valid = 1'b0; dec_ready = 1'b1;
    #1;
    vectors++; if (imem_en !== 1'b1) begin miscompares++; $display("FAIL rd_target_en: got %b want 1", imem_en); end
    vectors++; if (imem_addr !== 32'h40) begin miscompares++; $display("FAIL rd_target_addr: got %h want 40", imem_addr); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rd_n1_valid: got %b want 0", instr_valid); end
    tick; #1;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rd_n2_valid: got %b want 0", instr_valid); end
    tick;
    for (int j = 0; j < 3; j++) begin
      #1;
      vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL rd_valid[%0d]: got %b want 1", j, instr_valid); end
      vectors++; if (instr_addr !== 32'(32'h40 + 4*j)) begin miscompares++; $display("FAIL rd_pc[%0d]: got %h want %h", j, instr_addr, 32'(32'h40 + 4*j)); end
      vectors++; if (instr !== rom_word(32'(32'h40 + 4*j))) begin miscompares++; $display("FAIL rd_instr[%0d]: got %h want %h", j, instr, rom_word(32'(32'h40 + 4*j))); end
      tick;
    end
  endtask

  task automatic test_misaligned;
    jmp_addr = 32'h43; jmp_valid = 1'b1; dec_ready = 1'b1;
    #1;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL mis_strobe_valid: got %b want 0", instr_valid); end
    tick;
    jmp_valid = 1'b0;
    #1;
    vectors++; if (imem_en !== 1'b1) begin miscompares++; $display("FAIL mis_en: got %b want 1", imem_en); end
    vectors++; if (imem_addr !== 32'h40) begin miscompares++; $display("FAIL mis_addr: got %h want 40", imem_addr); end
    tick;
    tick; #1;
    vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL mis_valid: got %b want 1", instr_valid); end
    vectors++; if (instr_addr !== 32'h40) begin miscompares++; $display("FAIL mis_pc: got %h want 40", instr_addr); end
  endtask

  task automatic test_wrap;
    logic [AW-1:0] exp_pc;
    int got;
    exp_pc = 32'h100;
    got    = 0;
    tick;
    jmp_addr = 32'h100; jmp_valid = 1'b1; dec_ready = 1'b1;
    for (int c = 0; c < 300 && got < 20; c++) begin
      tick;
      jmp_valid = 1'b0;
      dec_ready = (c % 3 == 0);
      #1;
      if (instr_valid && dec_ready) begin
        vectors++; if (instr_addr !== exp_pc) begin miscompares++; $display("FAIL wrap_pc[%0d]: got %h want %h", got, instr_addr, exp_pc); end
        vectors++; if (instr !== rom_word(exp_pc)) begin miscompares++; $display("FAIL wrap_instr[%0d]: got %h want %h", got, instr, rom_word(exp_pc)); end
        exp_pc = exp_pc + 32'h4;
        got++;
      end
    end
    vectors++; if (got !== 20) begin miscompares++; $display("FAIL wrap_timeout: got %0d deliveries want 20", got); end
    dec_ready = 1'b1;
  endtask

  task automatic test_reset_midstream;
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick; #1;
      seen = imem_en;
    end
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL mid_no_request: got %b want 1", seen); end
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    vectors++; if (imem_en !== 1'b0) begin miscompares++; $display("FAIL mid_en: got %b want 0", imem_en); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_addr: got %h want 0", imem_addr); end
    vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL mid_instr: got %h want 0", instr); end
    vectors++; if (instr_addr !== 32'h0) begin miscompares++; $display("FAIL mid_instr_addr: got %h want 0", instr_addr); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b want 0", instr_valid); end
    @(negedge clk);
    rstn = 1'b1;
    test_boot("mid_boot", 4);
  endtask

  initial begin
    test_reset;
    test_boot("boot", 8);
    test_backpressure;
    test_redirect;
    test_misaligned;
    test_wrap;
    test_reset_midstream;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
